bitpack_ssm: RTL and testbench
==============================

BITPACK_SSM -- requirements
Module: bitpack_ssm

Interface
REQ-001 SHALL have parameter ssm_idx, default 0: substream index; tags this instance only and has no functional effect.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1: asynchronous active-low reset.
REQ-004 SHALL have port blk_vld  input  1: a codeword for the current block is offered.
REQ-005 SHALL have port blk_bits  input  128: the codeword, MSB-aligned; bits below blk_len are don't-care.
REQ-006 SHALL have port blk_len  input  8: codeword length in bits, legal range 0..128.
REQ-007 SHALL have port blk_rdy  output  1: packer accepts the codeword this cycle.
REQ-008 SHALL have port flush_req  input  1: single-cycle pulse requesting end-of-slice padding.
REQ-009 SHALL have port flush_done  output  1: single-cycle pulse when flush completes.
REQ-010 SHALL have port codec_data  output  128: packed substream word, first bit at bit 127.
REQ-011 SHALL have port codec_data_vld  output  1: codec_data holds a valid word.
REQ-012 SHALL have port codec_data_rdy  input  1: downstream takes the word.
REQ-013 SHALL have port total_bits  output  32: running count of accepted codeword bits (see Configuration).

Function
REQ-014 SHALL keep a 256-bit MSB-first accumulator plus a 9-bit fullness counter, range 0..256.
REQ-015 SHALL drive blk_rdy = (state==PACK) & (fullness<128), decoded from registers only.
REQ-016 SHALL, on accept (blk_vld & blk_rdy), write blk_bits[127 -: blk_len] immediately below the existing fullness bits and add blk_len to fullness.
REQ-017 SHALL treat blk_len==0 as an accepted no-op: fullness and accumulator unchanged.
REQ-018 SHALL take codec_data from accumulator[255:128] combinationally, and assert codec_data_vld when fullness>=128, or when in FLUSH with 0<fullness<128.
REQ-019 SHALL, on a transfer (codec_data_vld & codec_data_rdy), shift the accumulator left by 128 with zero fill and subtract 128 from fullness, saturating at 0 for a padded word.
REQ-020 SHALL ensure an accept and a transfer never coincide: blk_rdy is 0 whenever fullness>=128.
REQ-021 SHALL hold codec_data and codec_data_vld stable while codec_data_rdy is low.
REQ-022 SHALL implement states IDLE, PACK, FLUSH with these transitions:
- IDLE->PACK: one cycle after reset release.
- PACK->FLUSH: on flush_req; a codeword accepted in the same cycle is packed first.
- FLUSH->PACK: when fullness reaches 0, with flush_done pulsed in that transition cycle.
REQ-023 SHALL, in FLUSH, emit all full words first and then one zero-padded partial word; if fullness is 0 on entry, it pulses flush_done on the next cycle without emitting a word.
REQ-024 SHALL ignore flush_req outside PACK.
REQ-025 SHALL give first-word latency of one clock from the accept that brings fullness to >=128 until codec_data_vld.

Reset
REQ-026 SHALL, on rstn low, immediately clear: state=IDLE, fullness=0, accumulator=0, blk_rdy=0, codec_data=0, codec_data_vld=0, flush_done=0, total_bits=0.
REQ-027 SHALL discard all partially packed bits on a mid-operation reset, with no flush_done.

Configuration
REQ-028 SHALL, with BITPACK_BITCNT_EN defined, add blk_len to total_bits on every accept, wrapping modulo 2^32, clearing only at reset.
REQ-029 SHALL, without BITPACK_BITCNT_EN, tie total_bits to 0 and contain no counter logic.

Verification
REQ-030 SHALL cover: codeword len 100 = 0xF..F, then len 28 = 0x0..0 (rdy=1) -> one word with top 100 bits 1 and low 28 bits 0, vld one cycle after the second accept, fullness=0.
REQ-031 SHALL cover: two codewords of len 127 and len 1 with codec_data_rdy held low for 5 cycles -> vld stays 1, blk_rdy=0, codec_data stable; the word releases on rdy.
REQ-032 SHALL cover: codewords of len 128 and len 128 -> second accept stalls until the first word transfers; two words out in order.
REQ-033 SHALL cover: packed len 60 then flush_req -> one word with top 60 bits = data and low 68 bits = 0, then flush_done, state PACK, fullness 0.
REQ-034 SHALL cover: flush_req at fullness 0 -> flush_done the next cycle, no vld; len 0 codewords -> no change.
REQ-035 SHALL cover: rstn pulsed low with fullness 90 -> all outputs 0 asynchronously; total_bits (macro on) = 0 and counts 300 after codewords of len 100, 128, 72.

Source files
------------

// File: rtl/bitpack_ssm.sv
// rtl/bitpack_ssm.sv - MSB-first codeword packer for one substream, 128-bit output words.
// Optional running bit counter on total_bits when BITPACK_BITCNT_EN is defined.
module bitpack_ssm #(
  parameter int ssm_idx = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         blk_vld,
  input  logic [127:0] blk_bits,
  input  logic [7:0]   blk_len,
  output logic         blk_rdy,
  input  logic         flush_req,
  output logic         flush_done,
  output logic [127:0] codec_data,
  output logic         codec_data_vld,
  input  logic         codec_data_rdy,
  output logic [31:0]  total_bits
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t       state, state_nxt;
  logic [255:0] acc, acc_nxt;
  logic [8:0]   fullness, fullness_nxt;
  logic         accept, xfer;
  logic [127:0] len_mask, blk_masked;

  assign blk_rdy        = (state == PACK) && (fullness < 9'd128);
  assign codec_data     = acc[255:128];
  assign codec_data_vld = (fullness >= 9'd128) || ((state == FLUSH) && (fullness != 9'd0));
  assign accept         = blk_vld & blk_rdy;
  assign xfer           = codec_data_vld & codec_data_rdy;

  // Shifting all-ones by 128 yields zero, so a full-length codeword keeps every bit.
  assign len_mask   = ~({128{1'b1}} >> blk_len);
  assign blk_masked = blk_bits & len_mask;

  always_comb begin
    acc_nxt      = acc;
    fullness_nxt = fullness;
    state_nxt    = state;
    if (accept) begin
      acc_nxt      = acc | ({blk_masked, 128'b0} >> fullness);
      fullness_nxt = fullness + {1'b0, blk_len};
    end else if (xfer) begin
      acc_nxt      = {acc[127:0], 128'b0};
      fullness_nxt = (fullness >= 9'd128) ? (fullness - 9'd128) : 9'd0;
    end
    case (state)
      IDLE:    state_nxt = PACK;
      PACK:    if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (fullness == 9'd0) state_nxt = PACK;
      default: state_nxt = IDLE;
    endcase
  end

  // flush_done is high during the FLUSH cycle that sees an empty accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      acc        <= '0;
      fullness   <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      fullness   <= fullness_nxt;
      flush_done <= (state_nxt == FLUSH) && (fullness_nxt == 9'd0);
    end
  end

`ifdef BITPACK_BITCNT_EN
  logic [31:0] bit_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + {24'b0, blk_len};
    end
  end

  assign total_bits = bit_cnt;
`else
  assign total_bits = 32'd0;
`endif

endmodule

// File: tb/tb_bitpack_ssm.sv
// tb/tb_bitpack_ssm.sv - directed self-checking bench for bitpack_ssm.
module tb_bitpack_ssm;

  logic         clk = 1'b0;
  logic         rstn;
  logic         blk_vld;
  logic [127:0] blk_bits;
  logic [7:0]   blk_len;
  logic         blk_rdy;
  logic         flush_req;
  logic         flush_done;
  logic [127:0] codec_data;
  logic         codec_data_vld;
  logic         codec_data_rdy;
  logic [31:0]  total_bits;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ONES = {128{1'b1}};

  bitpack_ssm #(.ssm_idx(0)) dut (
    .clk(clk), .rstn(rstn),
    .blk_vld(blk_vld), .blk_bits(blk_bits), .blk_len(blk_len), .blk_rdy(blk_rdy),
    .flush_req(flush_req), .flush_done(flush_done),
    .codec_data(codec_data), .codec_data_vld(codec_data_vld), .codec_data_rdy(codec_data_rdy),
    .total_bits(total_bits)
  );

  always #5 clk = ~clk;

`ifdef BITPACK_BITCNT_EN
  function automatic logic [31:0] exp_bits(input logic [31:0] n);
    return n;
  endfunction
`else
  function automatic logic [31:0] exp_bits(input logic [31:0] n);
    return (n == 32'hFFFF_FFFF) ? 32'd1 : 32'd0;
  endfunction
`endif

  task automatic accept(input logic [127:0] b, input logic [7:0] l);
    int n;
    n = 0;
    @(negedge clk);
    blk_vld = 1'b1; blk_bits = b; blk_len = l;
    while (!blk_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: blk_rdy=%b required 1 within 50 cycles", blk_rdy);
    end
    @(posedge clk); #1;
    blk_vld = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; blk_vld = 1'b0; blk_bits = '0; blk_len = '0;
    flush_req = 1'b0; codec_data_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({blk_rdy, codec_data_vld, flush_done} !== 3'b000 || codec_data !== 128'd0 || total_bits !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/done=%b%b%b data=%h total=%0d required all 0",
               blk_rdy, codec_data_vld, flush_done, codec_data, total_bits);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_to_pack: blk_rdy=%b required 1", blk_rdy);
    end
  endtask

  task automatic test_pack_basic;
    logic [127:0] exp;
    exp = ONES << 28;
    accept(ONES, 8'd100);
    @(negedge clk);
    checks++;
    if (blk_rdy !== 1'b1 || codec_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_mid: rdy=%b vld=%b required rdy 1 vld 0", blk_rdy, codec_data_vld);
    end
    accept(128'h0, 8'd28);
    @(negedge clk);
    checks++;
    if (codec_data_vld !== 1'b1 || codec_data !== exp || blk_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: vld=%b data=%h rdy=%b required vld 1 data %h rdy 0",
               codec_data_vld, codec_data, blk_rdy, exp);
    end
    codec_data_rdy = 1'b1;
    @(posedge clk); #1;
    codec_data_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (codec_data_vld !== 1'b0 || dut.fullness !== 9'd0 || blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: vld=%b fullness=%0d rdy=%b required 0/0/1",
               codec_data_vld, dut.fullness, blk_rdy);
    end
  endtask

  task automatic test_stall;
    logic [127:0] exp;
    exp = 128'h0123456789ABCDEF_FEDCBA9876543211;
    accept(128'h0123456789ABCDEF_FEDCBA9876543210, 8'd127);
    accept(128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (codec_data_vld !== 1'b1 || blk_rdy !== 1'b0 || codec_data !== exp) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b data=%h required 1/0/%h",
                 i, codec_data_vld, blk_rdy, codec_data, exp);
      end
    end
    codec_data_rdy = 1'b1;
    @(posedge clk); #1;
    codec_data_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (codec_data_vld !== 1'b0 || blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: vld=%b rdy=%b required 0/1", codec_data_vld, blk_rdy);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] a, b;
    a = 128'hDEADBEEF_00112233_44556677_8899AABB;
    b = 128'hCAFEF00D_FFEEDDCC_BBAA9988_77665544;
    accept(a, 8'd128);
    @(negedge clk);
    blk_vld = 1'b1; blk_bits = b; blk_len = 8'd128;
    @(negedge clk);
    checks++;
    if (codec_data_vld !== 1'b1 || codec_data !== a || blk_rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: vld=%b data=%h rdy=%b required 1/%h/0",
               codec_data_vld, codec_data, blk_rdy, a);
    end
    codec_data_rdy = 1'b1;
    @(posedge clk); #1;
    codec_data_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (blk_rdy !== 1'b1 || codec_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: rdy=%b vld=%b required 1/0", blk_rdy, codec_data_vld);
    end
    @(posedge clk); #1;
    blk_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (codec_data_vld !== 1'b1 || codec_data !== b) begin
      errors++;
      $display("FAIL b2b_second: vld=%b data=%h required 1/%h", codec_data_vld, codec_data, b);
    end
    codec_data_rdy = 1'b1;
    @(posedge clk); #1;
    codec_data_rdy = 1'b0;
  endtask

  task automatic test_flush;
    logic [127:0] exp;
    exp = 128'hFEDCBA9876543210_0000000000000000;
    accept(128'hFEDCBA987654321F_FFFFFFFFFFFFFFFF, 8'd60);
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    checks++;
    if (codec_data_vld !== 1'b1 || codec_data !== exp || blk_rdy !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_word: vld=%b data=%h rdy=%b done=%b required 1/%h/0/0",
               codec_data_vld, codec_data, blk_rdy, flush_done, exp);
    end
    codec_data_rdy = 1'b1;
    @(posedge clk); #1;
    codec_data_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b1 || codec_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: done=%b vld=%b required 1/0", flush_done, codec_data_vld);
    end
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b0 || blk_rdy !== 1'b1 || dut.fullness !== 9'd0) begin
      errors++;
      $display("FAIL flush_exit: done=%b rdy=%b fullness=%0d required 0/1/0",
               flush_done, blk_rdy, dut.fullness);
    end
  endtask

  task automatic test_flush_empty;
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b1 || codec_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: done=%b vld=%b required 1/0", flush_done, codec_data_vld);
    end
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b0 || blk_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty_exit: done=%b rdy=%b required 0/1", flush_done, blk_rdy);
    end
    accept(ONES, 8'd0);
    accept(ONES, 8'd0);
    @(negedge clk);
    checks++;
    if (dut.fullness !== 9'd0 || codec_data_vld !== 1'b0 || codec_data !== 128'd0) begin
      errors++;
      $display("FAIL len_zero: fullness=%0d vld=%b data=%h required 0/0/0",
               dut.fullness, codec_data_vld, codec_data);
    end
  endtask

  task automatic test_reset_mid;
    accept(ONES, 8'd90);
    @(negedge clk);
    checks++;
    if (dut.fullness !== 9'd90 || total_bits !== exp_bits(32'd662)) begin
      errors++;
      $display("FAIL pre_reset: fullness=%0d total=%0d required 90/%0d",
               dut.fullness, total_bits, exp_bits(32'd662));
    end
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({blk_rdy, codec_data_vld, flush_done} !== 3'b000 || codec_data !== 128'd0 || total_bits !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: rdy/vld/done=%b%b%b data=%h total=%0d required all 0",
               blk_rdy, codec_data_vld, flush_done, codec_data, total_bits);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    codec_data_rdy = 1'b1;
    accept(ONES, 8'd100);
    accept(ONES, 8'd128);
    accept(ONES, 8'd72);
    @(negedge clk);
    checks++;
    if (total_bits !== exp_bits(32'd300) || dut.fullness !== 9'd172) begin
      errors++;
      $display("FAIL bit_count: total=%0d fullness=%0d required %0d/172",
               total_bits, dut.fullness, exp_bits(32'd300));
    end
    @(negedge clk);
    checks++;
    if (dut.fullness !== 9'd44 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL post_count_drain: fullness=%0d done=%b required 44/0", dut.fullness, flush_done);
    end
    codec_data_rdy = 1'b0;
  endtask

  initial begin
    test_reset;
    test_pack_basic;
    test_stall;
    test_back_to_back;
    test_flush;
    test_flush_empty;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
